// File: rtl/contador_vagas_pkg.sv
// Shared types and BCD arithmetic for the parking free-space counter.
// The count is kept as two BCD digits and is never converted to binary.
package contador_vagas_pkg;

    typedef logic [3:0] bcdNibble_t;

    typedef struct packed {
        bcdNibble_t dezena;
        bcdNibble_t unidade;
    } bcdCount_t;

    localparam logic [1:0] SEL_UNIDADE = 2'b01;
    localparam logic [1:0] SEL_DEZENA  = 2'b10;

    // Callers guarantee the count is below 99, so the tens digit cannot overflow.
    function automatic bcdCount_t bcd_inc(input bcdCount_t c);
        bcdCount_t r;
        r = c;
        if (c.unidade == 4'd9) begin
            r.unidade = 4'd0;
            r.dezena  = c.dezena + 4'd1;
        end else begin
            r.unidade = c.unidade + 4'd1;
        end
        return r;
    endfunction

    // Callers guarantee the count is above 00, so the tens digit cannot underflow.
    function automatic bcdCount_t bcd_dec(input bcdCount_t c);
        bcdCount_t r;
        r = c;
        if (c.unidade == 4'd0) begin
            r.unidade = 4'd9;
            r.dezena  = c.dezena - 4'd1;
        end else begin
            r.unidade = c.unidade - 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/debounce_sensor.sv
// Two-flop synchronizer, debounce counter and rising-edge event pulse
// for one raw car sensor.
module debounce_sensor #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sensorRaw,
    output logic evento
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             nivel;
    logic [CNT_W-1:0] cnt;

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values;
    // blocking ones here would collapse the two synchronizer stages into one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            nivel  <= 1'b0;
            cnt    <= '0;
            evento <= 1'b0;
        end else begin
            sync1  <= sensorRaw;
            sync2  <= sync1;
            evento <= 1'b0;
            // Any sample agreeing with the accepted level restarts the run.
            if (sync2 == nivel) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                nivel  <= sync2;
                cnt    <= '0;
                evento <= sync2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/contador_vagas_bcd.sv
// Free-space counter kept in two BCD digits, with debounced entry/exit
// sensors and a time-multiplexed digit bus for the 7-segment decoders.
module contador_vagas_bcd
    import contador_vagas_pkg::*;
#(
    parameter int CAPACITY        = 20,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SCAN_DIV        = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sensor_entrada,
    input  logic       sensor_saida,
    output logic [3:0] dezena,
    output logic [3:0] unidade,
    output logic [3:0] digito_bcd,
    output logic [1:0] digito_sel,
    output logic       lotado,
    output logic       vazio,
    output logic       erro
);

    localparam bcdCount_t CAP_BCD = '{dezena: 4'(CAPACITY / 10), unidade: 4'(CAPACITY % 10)};
    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    generate
        if (CAPACITY < 1 || CAPACITY > 99)  begin : gBadCapacity  $error("CAPACITY out of range"); end
        if (DEBOUNCE_CYCLES < 1)            begin : gBadDebounce  $error("DEBOUNCE_CYCLES below 1"); end
        if (SCAN_DIV < 2)                   begin : gBadScan      $error("SCAN_DIV below 2"); end
    endgenerate

    logic              evEnt;
    logic              evSai;
    bcdCount_t         count;
    bcdCount_t         nextCount;
    logic              nextErro;
    logic [SCAN_W-1:0] scanCnt;
    logic [1:0]        nextSel;

    debounce_sensor #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uEntrada (
        .clk       (clk),
        .rst_n     (rst_n),
        .sensorRaw (sensor_entrada),
        .evento    (evEnt)
    );

    debounce_sensor #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uSaida (
        .clk       (clk),
        .rst_n     (rst_n),
        .sensorRaw (sensor_saida),
        .evento    (evSai)
    );

    // NOTE: defaults first, so no branch leaves an output unassigned and no latch is inferred.
    always_comb begin
        nextCount = count;
        nextErro  = 1'b0;
        // Simultaneous entry and exit cancel out without flagging an error.
        if (evEnt && !evSai) begin
            if (count == '0) nextErro  = 1'b1;
            else             nextCount = bcd_dec(count);
        end else if (evSai && !evEnt) begin
            if (count == CAP_BCD) nextErro  = 1'b1;
            else                  nextCount = bcd_inc(count);
        end
    end

    always_comb begin
        nextSel = digito_sel;
        if (scanCnt == SCAN_LAST) begin
            nextSel = (digito_sel == SEL_UNIDADE) ? SEL_DEZENA : SEL_UNIDADE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count      <= CAP_BCD;
            lotado     <= 1'b0;
            vazio      <= 1'b1;
            erro       <= 1'b0;
            scanCnt    <= '0;
            digito_sel <= SEL_UNIDADE;
            digito_bcd <= CAP_BCD.unidade;
        end else begin
            count      <= nextCount;
            lotado     <= (nextCount == '0);
            vazio      <= (nextCount == CAP_BCD);
            erro       <= nextErro;
            scanCnt    <= (scanCnt == SCAN_LAST) ? '0 : scanCnt + SCAN_W'(1);
            digito_sel <= nextSel;
            // Built from next-state values so the bus never shows a stale digit.
            digito_bcd <= (nextSel == SEL_DEZENA) ? nextCount.dezena : nextCount.unidade;
        end
    end

    assign dezena  = count.dezena;
    assign unidade = count.unidade;

endmodule

// File: tb/tb_contador_vagas_bcd.sv
// Self-checking bench: directed vectors, multi-cycle corner sequences and
// randomized sensor waveforms against a behavioural free-space model.
module tb_contador_vagas_bcd;

    localparam int CAP  = 20;
    localparam int DEB  = 4;
    localparam int SCAN = 8;

    logic       clk;
    logic       rst_n;
    logic       sensor_entrada;
    logic       sensor_saida;
    logic [3:0] dezena;
    logic [3:0] unidade;
    logic [3:0] digito_bcd;
    logic [1:0] digito_sel;
    logic       lotado;
    logic       vazio;
    logic       erro;

    contador_vagas_bcd #(
        .CAPACITY        (CAP),
        .DEBOUNCE_CYCLES (DEB),
        .SCAN_DIV        (SCAN)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sensor_entrada (sensor_entrada),
        .sensor_saida   (sensor_saida),
        .dezena         (dezena),
        .unidade        (unidade),
        .digito_bcd     (digito_bcd),
        .digito_sel     (digito_sel),
        .lotado         (lotado),
        .vazio          (vazio),
        .erro           (erro)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: free spaces as an integer, sensor history as queues.
    int   freeM;
    int   edgesM;
    logic lvlE, lvlS, pendE, pendS, expErro;
    logic histE[$];
    logic histS[$];

    // The debounce stage sees the raw value from two edges earlier; a level
    // flips once the newest DEB such samples all disagree with it.
    function automatic logic windowDiffers(input logic h[$], input logic lvl);
        for (int j = 0; j < DEB; j++) begin
            int   idx;
            logic s;
            idx = h.size() - 3 - j;
            s   = (idx >= 0) ? h[idx] : 1'b0;
            if (s == lvl) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic modelReset();
        freeM = CAP; edgesM = 0;
        lvlE = 1'b0; lvlS = 1'b0; pendE = 1'b0; pendS = 1'b0; expErro = 1'b0;
        histE.delete(); histS.delete();
    endtask

    task automatic modelEdge(input logic ent, input logic sai);
        expErro = 1'b0;
        if (pendE && !pendS) begin
            if (freeM == 0) expErro = 1'b1; else freeM--;
        end else if (pendS && !pendE) begin
            if (freeM == CAP) expErro = 1'b1; else freeM++;
        end
        histE.push_back(ent);
        histS.push_back(sai);
        pendE = 1'b0;
        pendS = 1'b0;
        if (windowDiffers(histE, lvlE)) begin lvlE = ~lvlE; pendE = lvlE; end
        if (windowDiffers(histS, lvlS)) begin lvlS = ~lvlS; pendS = lvlS; end
        edgesM++;
    endtask

    task automatic checkModel();
        logic [1:0] sel;
        logic [3:0] d, u, b;
        d   = 4'(freeM / 10);
        u   = 4'(freeM % 10);
        sel = (((edgesM / SCAN) % 2) == 0) ? 2'b01 : 2'b10;
        b   = (sel == 2'b01) ? u : d;
        check("model", {dezena, unidade, lotado, vazio, erro, digito_sel, digito_bcd},
                       {d, u, (freeM == 0), (freeM == CAP), expErro, sel, b});
    endtask

    task automatic cycle(input logic ent, input logic sai);
        sensor_entrada = ent;
        sensor_saida   = sai;
        modelEdge(ent, sai);
        @(posedge clk);
        #1;
        checkModel();
    endtask

    task automatic doReset(input logic ent, input logic sai);
        rst_n          = 1'b0;
        sensor_entrada = ent;
        sensor_saida   = sai;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        modelReset();
        checkModel();
    endtask

    task automatic pulse(input logic ent, input logic sai, input int hold, input int idle,
                         output int erroCnt);
        erroCnt = 0;
        for (int i = 0; i < hold + idle; i++) begin
            if (i < hold) cycle(ent, sai);
            else          cycle(1'b0, 1'b0);
            if (erro) erroCnt++;
        end
    endtask

    typedef struct {
        logic       ent;
        logic       sai;
        int         hold;
        logic [3:0] dez;
        logic [3:0] uni;
        logic       lot;
        logic       vaz;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        logic entLvl, saiLvl;
        int   entLeft, saiLeft;

        rst_n = 1'b0;
        sensor_entrada = 1'b0;
        sensor_saida   = 1'b0;
        modelReset();

        // Reset state and free-running scan.
        doReset(1'b0, 1'b0);
        check("reset_state", {dezena, unidade, vazio, lotado, erro, digito_sel, digito_bcd},
                             {4'd2, 4'd0, 1'b1, 1'b0, 1'b0, 2'b01, 4'd0});
        repeat (SCAN) cycle(1'b0, 1'b0);
        check("scan_tens", {digito_sel, digito_bcd}, {2'b10, 4'd2});
        repeat (SCAN) cycle(1'b0, 1'b0);
        check("scan_units", {digito_sel, digito_bcd}, {2'b01, 4'd0});

        // Entry held 10 clocks: one decrement exactly 7 clocks after the raw edge.
        repeat (6) cycle(1'b1, 1'b0);
        check("latency_before", {dezena, unidade, vazio}, {4'd2, 4'd0, 1'b1});
        cycle(1'b1, 1'b0);
        check("latency_at7", {dezena, unidade, vazio}, {4'd1, 4'd9, 1'b0});
        repeat (3) cycle(1'b1, 1'b0);
        repeat (10) cycle(1'b0, 1'b0);
        check("single_event", {dezena, unidade}, {4'd1, 4'd9});

        // Directed vectors from a fresh reset.
        vecs[0] = '{1'b1, 1'b0, 10, 4'd1, 4'd9, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0,  3, 4'd1, 4'd9, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 10, 4'd2, 4'd0, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 10, 4'd2, 4'd0, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 10, 4'd2, 4'd0, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 1'b0,  5, 4'd1, 4'd9, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b0,  4, 4'd1, 4'd8, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b1,  6, 4'd1, 4'd9, 1'b0, 1'b0};
        doReset(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            repeat (vecs[i].hold) cycle(vecs[i].ent, vecs[i].sai);
            repeat (10) cycle(1'b0, 1'b0);
            check($sformatf("vec%0d", i), {dezena, unidade, lotado, vazio},
                  {vecs[i].dez, vecs[i].uni, vecs[i].lot, vecs[i].vaz});
        end

        // Fill to zero, then one entry too many, then one exit.
        doReset(1'b0, 1'b0);
        for (int i = 0; i < CAP; i++) pulse(1'b1, 1'b0, 5, 8, e);
        check("full_count", {dezena, unidade, lotado}, {4'd0, 4'd0, 1'b1});
        pulse(1'b1, 1'b0, 5, 8, e);
        check("full_erro_pulses", e, 1);
        check("full_hold", {dezena, unidade, lotado}, {4'd0, 4'd0, 1'b1});
        pulse(1'b0, 1'b1, 5, 8, e);
        check("after_exit", {dezena, unidade, lotado}, {4'd0, 4'd1, 1'b0});

        // Exit at empty lot, then simultaneous events at 10.
        doReset(1'b0, 1'b0);
        pulse(1'b0, 1'b1, 5, 8, e);
        check("empty_erro_pulses", e, 1);
        check("empty_hold", {dezena, unidade, vazio}, {4'd2, 4'd0, 1'b1});
        for (int i = 0; i < 10; i++) pulse(1'b1, 1'b0, 5, 8, e);
        check("at_ten", {dezena, unidade}, {4'd1, 4'd0});
        pulse(1'b1, 1'b1, 6, 10, e);
        check("simult_erro", e, 0);
        check("simult_hold", {dezena, unidade}, {4'd1, 4'd0});

        // Reset in the middle of a debounce run at free=09.
        doReset(1'b0, 1'b0);
        for (int i = 0; i < 11; i++) pulse(1'b1, 1'b0, 5, 8, e);
        check("at_nine", {dezena, unidade}, {4'd0, 4'd9});
        repeat (4) cycle(1'b1, 1'b0);
        doReset(1'b1, 1'b0);
        pulse(1'b0, 1'b0, 0, 14, e);
        check("abort_erro", e, 0);
        check("abort_count", {dezena, unidade, vazio}, {4'd2, 4'd0, 1'b1});

        // Randomized waveforms: entry-heavy phase, then exit-heavy phase.
        doReset(1'b0, 1'b0);
        entLvl = 1'b0; saiLvl = 1'b0; entLeft = 0; saiLeft = 0;
        for (int n = 0; n < 3000; n++) begin
            if (entLeft == 0) begin
                entLvl  = ($urandom_range(0, 3) < ((n < 1500) ? 2 : 1)) ? 1'b1 : 1'b0;
                entLeft = $urandom_range(1, 9);
            end
            if (saiLeft == 0) begin
                saiLvl  = ($urandom_range(0, 3) < ((n < 1500) ? 1 : 2)) ? 1'b1 : 1'b0;
                saiLeft = $urandom_range(1, 9);
            end
            entLeft--;
            saiLeft--;
            cycle(entLvl, saiLvl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/contador_vagas_bcd.md
Name: contador_vagas_bcd

Overview:
Sequential front end that produces the BCD nibbles the parking display's 7-segment decoders consume. It debounces the raw entry and exit car sensors and keeps a free-space count directly in two BCD digits. It also time-multiplexes the two digits onto one 4-bit bus (bit 3 = MSB, driven into decoder input b0) with a one-hot digit select.

Parameters:
CAPACITY, 20, total parking spaces; legal range 1..99; also the reset value of the free count.
DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required to accept a sensor level change; minimum 1.
SCAN_DIV, 8, clock cycles each digit is held on the multiplexed bus; minimum 2.

Ports:
clk  in  1  single system clock; all state changes on the rising edge.
rst_n  in  1  synchronous active-low reset.
sensor_entrada  in  1  raw entry sensor, asynchronous, active high while a car is present.
sensor_saida  in  1  raw exit sensor, asynchronous, active high while a car is present.
dezena  out  4  BCD tens digit of the free count.
unidade  out  4  BCD units digit of the free count.
digito_bcd  out  4  multiplexed digit; bit 3 = MSB, maps to decoder b0.
digito_sel  out  2  one-hot select; 2'b01 = units, 2'b10 = tens.
lotado  out  1  high when the free count is 0.
vazio  out  1  high when the free count equals CAPACITY.
erro  out  1  one-cycle pulse when an event is rejected.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - free count = CAPACITY, so dezena = CAPACITY/10 and unidade = CAPACITY%10.
  - lotado=0, vazio=1, erro=0.
  - Scan counter = 0, digito_sel=2'b01, digito_bcd=unidade.
  - Synchronizers and debounced levels = 0.
  - Reset mid-event discards any partially debounced edge.
- Sensor path, per sensor:
  - 2-flop synchronizer, then a debounce counter.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive synchronized samples that differ from it. Any matching sample clears the counter.
  - A debounced 0->1 transition produces a one-cycle event pulse (ev_ent / ev_sai).
  - Latency from a raw rising edge to the count update is 2 + DEBOUNCE_CYCLES + 1 clocks.
- Count update, registered on the cycle after the event pulse:
  - ev_ent alone, free>0: decrement in BCD. Units 0 -> 9 with tens borrow.
  - ev_ent alone, free=0: no change; erro pulses.
  - ev_sai alone, free<CAPACITY: increment in BCD. Units 9 -> 0 with tens carry.
  - ev_sai alone, free=CAPACITY: no change; erro pulses.
  - ev_ent and ev_sai in the same cycle: no change, no erro.
  - Nibble values are never outside 0..9. The count is never binary-converted.
- Flags: lotado and vazio are registered and valid in the same cycle as the updated dezena/unidade.
- Scan:
  - Counter runs 0..SCAN_DIV-1. At wrap, digito_sel toggles between 2'b01 and 2'b10.
  - digito_bcd is registered from the selected digit, so it follows a count change within 1 clock.
  - The scan runs freely and is independent of events.
  - digito_sel is never 2'b00 or 2'b11.
- Sensors held high produce exactly one event. A new event requires a debounced return to 0 first.

Decomposition:
- Package contador_vagas_pkg: BCD nibble typedef, SEL_UNIDADE=2'b01, SEL_DEZENA=2'b10, and functions bcd_inc and bcd_dec on {tens, units}.
- Sub-module debounce_sensor: synchronizer, debounce counter and rising-edge pulse. Instantiated twice.

Test Plan:
- Reset with CAPACITY=20: dezena=2, unidade=0, vazio=1, lotado=0. digito_sel alternates 01/10 every 8 clocks; digito_bcd alternates 0/2.
- Entry pulse held 10 clocks: exactly one decrement to 19 (dezena=1, unidade=9) exactly 7 clocks after the raw edge; vazio falls in the same cycle.
- Glitch of 3 clocks on sensor_entrada (DEBOUNCE_CYCLES=4): count stays 20, erro stays 0.
- 20 clean entries, then a 21st: count 00 and lotado=1 after the 20th; the 21st gives a 1-clock erro and the count stays 00. Then 1 exit: count 01, lotado=0.
- At free=20, one exit: erro pulses, count stays 20. Entry and exit debounced in the same cycle at free=10: count stays 10, no erro.
- rst_n asserted for 1 clock at free=09, with an entry 2 clocks into debounce: count returns to 20 and no event fires from the aborted edge.
